// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and constants for the sequential divider.
//   div_state_e          - divider FSM state encoding
//   DIV_START / DIV_STOP - levels of the start request
//   DIV_RESULT_READY / DIV_RESULT_NOT_READY - levels of the ready flag
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// div_seq_step: one combinational radix-2 restoring division step.
//   rem_i      - current partial remainder (always < divisor_i)
//   next_bit_i - next dividend bit shifted into the remainder
//   divisor_i  - divisor magnitude (non-zero)
//   rem_o      - partial remainder after the step
//   qbit_o     - quotient bit produced by the step
module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             next_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Because rem_i < divisor_i, the shifted value is below 2*divisor, so a
    // W+1-bit trial difference has its MSB set exactly when it went negative.
    assign shifted = {rem_i, next_bit_i};
    assign trial   = shifted - {1'b0, divisor_i};
    assign qbit_o  = ~trial[WIDTH];
    assign rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV/DIVU.
//   clk, rst           - clock, synchronous active-high reset
//   signed_div_i       - 1 = signed DIV, 0 = unsigned DIVU (sampled with start)
//   opdata1_i/2_i      - dividend / divisor (sampled with start)
//   start_i            - request, held until ready_o
//   annul_i            - cancel the in-flight division
//   result_o           - {remainder, quotient}
//   ready_o            - result_o valid
//   busy_o             - division in progress (BYZERO or ON)
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;       // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   quo_next;

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem_i      (rem_q),
        .next_bit_i (quo_q[WIDTH-1]),
        .divisor_i  (divisor_q),
        .rem_o      (step_rem),
        .qbit_o     (step_qbit)
    );

    assign quo_next = {quo_q[WIDTH-2:0], step_qbit};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            DIV_FREE: begin
                ready_d = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    // Work on magnitudes; the original signs drive the final correction.
                    neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                    quo_d     = cond_neg(signed_div_i & opdata1_i[WIDTH-1], opdata1_i);
                    divisor_d = cond_neg(signed_div_i & opdata2_i[WIDTH-1], opdata2_i);
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    // Division by zero is defined to return all zeros.
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    rem_d = step_rem;
                    quo_d = quo_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = {cond_neg(neg_rem_q, step_rem), cond_neg(neg_quo_q, quo_next)};
                        ready_d  = DIV_RESULT_READY;
                        state_d  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DIV_STOP) begin
                    ready_d = DIV_RESULT_NOT_READY;
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        // Datapath registers carry no reset; they are always reloaded on start.
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        divisor_q <= divisor_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == DIV_BYZERO) || (state_q == DIV_ON);

endmodule
